sdp_bram_be_clr: RTL

//   Single-clock simple dual-port block RAM with per-byte write enables, selectable collision mode,

---
 rtl/sdp_bram_be_clr.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/sdp_bram_be_clr.sv
// Simple dual-port block RAM with byte-lane write enables, READ_FIRST/WRITE_FIRST collision
// handling, a READ_LATENCY-deep read pipeline with valid strobe, and a zero-fill clear engine.
module sdp_bram_be_clr #(
    parameter int    RAM_WIDTH      = 32,
    parameter int    BYTE_W         = 8,
    parameter int    RAM_DEPTH      = 1024,
    parameter int    READ_LATENCY   = 2,
    parameter string WRITE_MODE     = "READ_FIRST",
    parameter int    CLEAR_ON_RESET = 1,
    parameter string INIT_FILE      = "",
    localparam int   NB             = RAM_WIDTH / BYTE_W,
    localparam int   AW             = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
    input  logic                 clka,
    input  logic                 rstb,
    input  logic                 wea,
    input  logic [AW-1:0]        addra,
    input  logic [RAM_WIDTH-1:0] dina,
    input  logic [NB-1:0]        bea,
    input  logic                 rea,
    input  logic [AW-1:0]        addrb,
    output logic [RAM_WIDTH-1:0] doutb,
    output logic                 doutb_valid,
    input  logic                 clear_req,
    output logic                 busy
);

    generate
        if ((RAM_WIDTH < BYTE_W) || ((RAM_WIDTH % BYTE_W) != 0)) begin : g_bad_width
            $error("sdp_bram_be_clr: RAM_WIDTH must be a non-zero multiple of BYTE_W");
        end
        if ((READ_LATENCY < 1) || (READ_LATENCY > 4)) begin : g_bad_latency
            $error("sdp_bram_be_clr: READ_LATENCY must be in 1..4");
        end
        if ((WRITE_MODE != "READ_FIRST") && (WRITE_MODE != "WRITE_FIRST")) begin : g_bad_mode
            $error("sdp_bram_be_clr: WRITE_MODE must be READ_FIRST or WRITE_FIRST");
        end
    endgenerate

    localparam bit            WRITE_FIRST = (WRITE_MODE == "WRITE_FIRST");
    localparam logic [AW:0]   DEPTH_W     = (AW + 1)'(RAM_DEPTH);
    localparam logic [AW-1:0] LAST_ADDR   = AW'(RAM_DEPTH - 1);

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } state_e;

    state_e        state_q;
    logic          busy_q;
    logic [AW-1:0] clr_cnt_q;
    logic [AW-1:0] clr_cnt_d;

    logic                 wr_req;
    logic                 rd_req;
    logic                 wa_ok;
    logic                 rb_ok;
    logic [NB-1:0]        mem_be;
    logic [AW-1:0]        mem_waddr;
    logic [RAM_WIDTH-1:0] mem_wdata;
    logic [RAM_WIDTH-1:0] rd_word;

    // NOTE: the storage array has no reset term so it maps onto block RAM; zeroing is the clear engine's job.
    logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

    // User accesses are locked out while clearing and on the reset edge itself.
    assign wr_req    = wea & ~busy_q & ~rstb;
    assign rd_req    = rea & ~busy_q & ~rstb;
    assign wa_ok     = ({1'b0, addra} < DEPTH_W);
    assign rb_ok     = ({1'b0, addrb} < DEPTH_W);
    assign clr_cnt_d = clr_cnt_q + AW'(1);

    // Single physical write port shared by the clear sweep and user writes.
    always_comb begin
        // NOTE: every output of this block is given a default first, so no path can infer a latch.
        mem_be    = '0;
        mem_waddr = addra;
        mem_wdata = dina;
        if (!rstb && (state_q == S_CLEAR)) begin
            mem_be    = '1;
            mem_waddr = clr_cnt_q;
            mem_wdata = '0;
        end else if (wr_req && wa_ok) begin
            mem_be = bea;
        end
    end

    always_ff @(posedge clka) begin
        for (int i = 0; i < NB; i++) begin
            if (mem_be[i]) begin
                mem[mem_waddr][i*BYTE_W +: BYTE_W] <= mem_wdata[i*BYTE_W +: BYTE_W];
            end
        end
    end

    always_comb begin
        rd_word = '0;
        if (rb_ok) begin
            rd_word = mem[addrb];
            if (WRITE_FIRST && (mem_waddr == addrb)) begin
                for (int i = 0; i < NB; i++) begin
                    if (mem_be[i]) begin
                        rd_word[i*BYTE_W +: BYTE_W] = mem_wdata[i*BYTE_W +: BYTE_W];
                    end
                end
            end
        end
    end

    // Data stages advance only alongside a valid token, so doutb holds between results.
    logic [RAM_WIDTH-1:0]    rd_dat_q [READ_LATENCY];
    logic [READ_LATENCY-1:0] rd_vld_q;

    always_ff @(posedge clka) begin
        if (rstb) begin
            rd_vld_q <= '0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                rd_dat_q[k] <= '0;
            end
        end else begin
            rd_vld_q[0] <= rd_req;
            if (rd_req) begin
                rd_dat_q[0] <= rd_word;
            end
            for (int k = 1; k < READ_LATENCY; k++) begin
                rd_vld_q[k] <= rd_vld_q[k-1];
                if (rd_vld_q[k-1]) begin
                    rd_dat_q[k] <= rd_dat_q[k-1];
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clka) begin
        if (rstb) begin
            clr_cnt_q <= '0;
            if (CLEAR_ON_RESET != 0) begin
                state_q <= S_CLEAR;
                busy_q  <= 1'b1;
            end else begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (clear_req) begin
                        state_q   <= S_CLEAR;
                        busy_q    <= 1'b1;
                        clr_cnt_q <= '0;
                    end
                end
                S_CLEAR: begin
                    if (clr_cnt_q == LAST_ADDR) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        clr_cnt_q <= clr_cnt_d;
                    end
                end
            endcase
        end
    end

    assign doutb       = rd_dat_q[READ_LATENCY-1];
    assign doutb_valid = rd_vld_q[READ_LATENCY-1];
    assign busy        = busy_q;

endmodule
